// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring-divide unit producing a MIPS-style HI/LO pair.
// Signed ops work on magnitudes and apply the recorded signs in a two-cycle FIX phase.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               accept_s, dbz_in_s;
  logic               op_div_r, neg_q_r, neg_r_r, dbz_r, fix_phase_r;
  logic [WIDTH-1:0]   b_mag_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, dbz_flag_r;

  logic [WIDTH-1:0]   acc_hi_s, acc_lo_s;
  logic [WIDTH:0]     sum_s, shifted_s, diff_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, fixed_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when it is a negative signed operand, otherwise v itself
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign dbz_in_s = op[1] && (input_b == {WIDTH{1'b0}});
  assign acc_hi_s = acc_r[2*WIDTH-1:WIDTH];
  assign acc_lo_s = acc_r[WIDTH-1:0];

  assign busy        = busy_r;
  assign done        = done_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dbz_flag_r;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = dbz_in_s ? FIX : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX: begin
        if (fix_phase_r) begin
          state_s = DONE;
        end else begin
          state_s = FIX;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One shift-add step, one restoring-divide step and the sign-corrected result
  always_comb begin
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_hi_s} + {1'b0, b_mag_r};
    end else begin
      sum_s = {1'b0, acc_hi_s};
    end
    mul_next_s = {sum_s, acc_lo_s[WIDTH-1:1]};

    // Remainder lives in the upper half, dividend shifts out of the lower half as quotient shifts in
    shifted_s = {acc_hi_s, acc_lo_s[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, b_mag_r};
    if (shifted_s >= {1'b0, b_mag_r}) begin
      div_next_s = {diff_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {shifted_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
    end

    if (dbz_r) begin
      fixed_s = {acc_lo_s, {WIDTH{1'b1}}};
    end else if (op_div_r) begin
      fixed_s = {(neg_r_r ? neg_w(acc_hi_s) : acc_hi_s),
                 (neg_q_r ? neg_w(acc_lo_s) : acc_lo_s)};
    end else if (neg_q_r) begin
      fixed_s = neg_2w(acc_r);
    end else begin
      fixed_s = acc_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      dbz_r       <= 1'b0;
      fix_phase_r <= 1'b0;
      b_mag_r     <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CW{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_flag_r  <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN) || (state_s == FIX);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            op_div_r    <= op[1];
            neg_q_r     <= op[0] && (input_a[WIDTH-1] ^ input_b[WIDTH-1]);
            neg_r_r     <= op[0] && input_a[WIDTH-1];
            dbz_r       <= dbz_in_s;
            b_mag_r     <= mag(input_b, op[0]);
            // On divide by zero the raw dividend is kept so it can be returned unchanged
            acc_r       <= {{WIDTH{1'b0}}, (dbz_in_s ? input_a : mag(input_a, op[0]))};
            cnt_r       <= {CW{1'b0}};
            fix_phase_r <= 1'b0;
            dbz_flag_r  <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= op_div_r ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          if (!fix_phase_r) begin
            acc_r       <= fixed_s;
            fix_phase_r <= 1'b1;
          end else begin
            hi_r        <= acc_hi_s;
            lo_r        <= acc_lo_s;
            dbz_flag_r  <= dbz_r;
            fix_phase_r <= 1'b0;
          end
        end
        default: begin
          fix_phase_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] input_a, input_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .input_a(input_a), .input_b(input_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO results from plain integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic [63:0]        p;
    logic signed [63:0] sa, sb, sp;
    int                 ia, ib;
    z = 1'b0;
    h = 32'd0;
    l = 32'd0;
    case (o)
      2'd0: begin
        p = {32'd0, a} * {32'd0, b};
        {h, l} = p;
      end
      2'd1: begin
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        {h, l} = sp;
      end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = a;
          z = 1'b1;
        end else if (o == 2'd2) begin
          l = a / b;
          h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          ia = a;
          ib = b;
          l = ia / ib;
          h = ia % ib;
        end
      end
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, and wait (bounded) for done
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic z, output logic to);
    @(negedge clk);
    op = o; input_a = a; input_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); input_a = $urandom; input_b = $urandom;
    lat = 0;
    to  = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        to  = 1'b0;
        break;
      end
    end
    h = hi; l = lo; z = div_by_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; input_a = 32'd0; input_b = 32'd0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo hi=%h lo=%h want 0 0", hi, lo); end
    checks++; if (div_by_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags dbz=%b busy=%b want 0 0", div_by_zero, busy); end
  endtask

  task automatic test_directed;
    logic [1:0]   ops [6]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [W-1:0] as  [6]  = '{32'd550, 32'hFFFF_FFFD, 32'h8000_0000, 32'd550, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [W-1:0] bs  [6]  = '{32'd450, 32'd7, 32'h8000_0000, 32'd450, 32'd2, 32'hFFFF_FFFF};
    logic [W-1:0] ehs [6]  = '{32'd0, 32'hFFFF_FFFF, 32'h4000_0000, 32'd100, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] els [6]  = '{32'h0003_C6CC, 32'hFFFF_FFEB, 32'd0, 32'd1, 32'hFFFF_FFFD, 32'h8000_0000};
    int lat; logic [W-1:0] h, l; logic z, to;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat, h, l, z, to);
      checks++; if (to || lat != LAT) begin errors++; $display("FAIL dir_latency[%0d] got=%0d timeout=%b want %0d", i, lat, to, LAT); end
      checks++; if (h !== ehs[i] || l !== els[i]) begin errors++; $display("FAIL dir_result[%0d] hi=%h lo=%h want %h %h", i, h, l, ehs[i], els[i]); end
      checks++; if (busy !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL dir_flags[%0d] busy=%b dbz=%b want 0 0", i, busy, z); end
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [W-1:0] h, l, eh, el; logic z, ez, to;
    run_op(2'd3, 32'd100, 32'd0, lat, h, l, z, to);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL dbz_latency got=%0d timeout=%b want 2", lat, to); end
    checks++; if (h !== 32'd100 || l !== 32'hFFFF_FFFF || z !== 1'b1) begin errors++; $display("FAIL dbz_result hi=%h lo=%h dbz=%b want 64 ffffffff 1", h, l, z); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (div_by_zero !== 1'b1 || hi !== 32'd100) begin errors++; $display("FAIL dbz_hold dbz=%b hi=%h want 1 64", div_by_zero, hi); end
    run_op(2'd2, 32'd10, 32'd3, lat, h, l, z, to);
    checks++; if (to || z !== 1'b0 || h !== 32'd1 || l !== 32'd3) begin errors++; $display("FAIL dbz_clear dbz=%b hi=%h lo=%h want 0 1 3", z, h, l); end
    run_op(2'd2, 32'hDEAD_BEEF, 32'd0, lat, h, l, z, to);
    model(2'd2, 32'hDEAD_BEEF, 32'd0, eh, el, ez);
    checks++; if (to || lat != 2 || h !== eh || l !== el || z !== ez) begin errors++; $display("FAIL dbz_divu lat=%0d hi=%h lo=%h dbz=%b want 2 %h %h %b", lat, h, l, z, eh, el, ez); end
  endtask

  task automatic test_random;
    int lat; logic [W-1:0] a, b, h, l, eh, el; logic [1:0] o; logic z, ez, to;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = (($urandom & 32'd7) == 32'd0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(o, a, b, eh, el, ez);
      run_op(o, a, b, lat, h, l, z, to);
      checks++;
      if (to || lat != (ez ? 2 : LAT) || h !== eh || l !== el || z !== ez) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h lat=%0d hi=%h lo=%h dbz=%b want lat=%0d %h %h %b",
                 n, o, a, b, lat, h, l, z, (ez ? 2 : LAT), eh, el, ez);
      end
    end
  endtask

  task automatic test_start_during_run;
    int pulses = 0; logic [W-1:0] h, l, eh, el; logic z, ez;
    model(2'd1, 32'hFFFF_FF00, 32'd12345, eh, el, ez);
    @(negedge clk);
    op = 2'd1; input_a = 32'hFFFF_FF00; input_b = 32'd12345; start = 1'b1;
    @(posedge clk); #1;
    h = 32'd0; l = 32'd0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      start = busy; op = 2'($urandom); input_a = $urandom; input_b = $urandom;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        h = hi; l = lo;
      end
    end
    start = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_start pulses=%0d want 1", pulses); end
    checks++; if (h !== eh || l !== el) begin errors++; $display("FAIL ignore_start_result hi=%h lo=%h want %h %h", h, l, eh, el); end
  endtask

  task automatic test_back_to_back;
    int lat = 0; logic to = 1'b1; logic [W-1:0] h, l, eh, el; logic z, ez;
    run_op(2'd0, 32'd1000, 32'd3000, lat, h, l, z, to);
    checks++; if (to || h !== 32'd0 || l !== 32'd3000000) begin errors++; $display("FAIL b2b_first hi=%h lo=%h want 0 2dc6c0", h, l); end
    model(2'd3, 32'hFFFF_FC00, 32'd7, eh, el, ez);
    op = 2'd3; input_a = 32'hFFFF_FC00; input_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want 1", busy); end
    to = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; to = 1'b0; break; end
    end
    checks++; if (to || lat != LAT || hi !== eh || lo !== el) begin errors++; $display("FAIL b2b_second lat=%0d hi=%h lo=%h want %0d %h %h", lat, hi, lo, LAT, eh, el); end
  endtask

  task automatic test_reset_mid;
    int lat; int pulses = 0; logic [W-1:0] h, l; logic z, to;
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat, h, l, z, to);
    @(negedge clk);
    op = 2'd0; input_a = 32'd99; input_b = 32'd77; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy busy=%b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rst_mid_clear busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet pulses=%0d busy=%b want 0 0", pulses, busy); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
